// File: rtl/ncc_pkg.sv
// Shared defaults, width helpers and the line-sum record for the NCC window accumulator.
package ncc_pkg;

    localparam int unsigned PIXEL_SIZE_DEF    = 8;
    localparam int unsigned LINE_SIZE_DEF     = 8;
    localparam int unsigned NUM_TEMPLATES_DEF = 4;
    localparam int unsigned NUM_OF_LINES_DEF  = 8;

    function automatic int unsigned line_w(input int unsigned pixel_size,
                                           input int unsigned line_size);
        return $clog2(line_size) + 2 * pixel_size;
    endfunction

    function automatic int unsigned acc_w(input int unsigned pixel_size,
                                          input int unsigned line_size,
                                          input int unsigned num_of_lines);
        return $clog2(num_of_lines) + line_w(pixel_size, line_size);
    endfunction

    localparam int unsigned LINE_W_DEF = line_w(PIXEL_SIZE_DEF, LINE_SIZE_DEF);

    typedef struct packed {
        logic [LINE_W_DEF-1:0]                        i;
        logic [LINE_W_DEF-1:0]                        i2;
        logic [NUM_TEMPLATES_DEF-1:0][LINE_W_DEF-1:0] ti;
    } line_sum_t;

endpackage

// File: rtl/ncc_line_reduce.sv
// Combinational reduction of one image line (and its template lines) to sum I, sum I^2, sum T_k*I.
module ncc_line_reduce
    import ncc_pkg::*;
#(
    parameter int unsigned PIXEL_SIZE    = PIXEL_SIZE_DEF,
    parameter int unsigned LINE_SIZE     = LINE_SIZE_DEF,
    parameter int unsigned NUM_TEMPLATES = NUM_TEMPLATES_DEF,
    parameter int unsigned LINE_W        = line_w(PIXEL_SIZE, LINE_SIZE),
    parameter type         sum_t         = line_sum_t
) (
    input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                    i_line_i,
    input  logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] t_line_i,
    output sum_t                                                    sum_o
);

    localparam int unsigned PadW = LINE_W - 2 * PIXEL_SIZE;

    always_comb begin
        logic [2*PIXEL_SIZE-1:0] sq;
        logic [2*PIXEL_SIZE-1:0] prod;
        sum_o = '0;
        for (int p = 0; p < LINE_SIZE; p++) begin
            sq      = {{PIXEL_SIZE{1'b0}}, i_line_i[p]} * {{PIXEL_SIZE{1'b0}}, i_line_i[p]};
            sum_o.i  = sum_o.i + {{(LINE_W - PIXEL_SIZE){1'b0}}, i_line_i[p]};
            sum_o.i2 = sum_o.i2 + {{PadW{1'b0}}, sq};
            for (int k = 0; k < NUM_TEMPLATES; k++) begin
                prod = {{PIXEL_SIZE{1'b0}}, t_line_i[p][k]} * {{PIXEL_SIZE{1'b0}}, i_line_i[p]};
                sum_o.ti[k] = sum_o.ti[k] + {{PadW{1'b0}}, prod};
            end
        end
    end

endmodule

// File: rtl/ncc_window_acc.sv
// Two-stage NCC line accumulator: registered line reduce, then window accumulate with a
// held, back-pressured result per NUM_OF_LINES-line window.
module ncc_window_acc
    import ncc_pkg::*;
#(
    parameter int unsigned PIXEL_SIZE    = PIXEL_SIZE_DEF,
    parameter int unsigned LINE_SIZE     = LINE_SIZE_DEF,
    parameter int unsigned NUM_TEMPLATES = NUM_TEMPLATES_DEF,
    parameter int unsigned NUM_OF_LINES  = NUM_OF_LINES_DEF,
    localparam int unsigned LINE_W       = line_w(PIXEL_SIZE, LINE_SIZE),
    localparam int unsigned ACC_W        = acc_w(PIXEL_SIZE, LINE_SIZE, NUM_OF_LINES),
    localparam int unsigned CNT_W        = $clog2(NUM_OF_LINES)
) (
    input  logic                                                    CLK,
    input  logic                                                    reset,
    input  logic                                                    clear,
    input  logic                                                    in_valid,
    output logic                                                    in_ready,
    input  logic [LINE_SIZE-1:0][PIXEL_SIZE-1:0]                    I_in_line,
    input  logic [LINE_SIZE-1:0][NUM_TEMPLATES-1:0][PIXEL_SIZE-1:0] T_in_line,
    output logic                                                    out_valid,
    input  logic                                                    out_ready,
    output logic [ACC_W-1:0]                                        Acc_lines_sum_I,
    output logic [ACC_W-1:0]                                        Acc_lines_sum_I_square,
    output logic [NUM_TEMPLATES-1:0][ACC_W-1:0]                     Acc_lines_sum_T_x_I,
    output logic [CNT_W-1:0]                                        line_count
);

    typedef struct packed {
        logic [LINE_W-1:0]                    i;
        logic [LINE_W-1:0]                    i2;
        logic [NUM_TEMPLATES-1:0][LINE_W-1:0] ti;
    } lsum_t;

    typedef struct packed {
        logic [ACC_W-1:0]                    i;
        logic [ACC_W-1:0]                    i2;
        logic [NUM_TEMPLATES-1:0][ACC_W-1:0] ti;
    } asum_t;

    lsum_t            line_sum;
    lsum_t            s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    asum_t            acc_q, acc_d, acc_sum;
    asum_t            res_q, res_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             completing, stall2, adv2, accept;

    ncc_line_reduce #(
        .PIXEL_SIZE   (PIXEL_SIZE),
        .LINE_SIZE    (LINE_SIZE),
        .NUM_TEMPLATES(NUM_TEMPLATES),
        .LINE_W       (LINE_W),
        .sum_t        (lsum_t)
    ) u_line_reduce (
        .i_line_i(I_in_line),
        .t_line_i(T_in_line),
        .sum_o   (line_sum)
    );

    assign completing = (cnt_q == CNT_W'(NUM_OF_LINES - 1));
    // Stage 2 only waits when it would overwrite a result the consumer has not taken.
    assign stall2     = s1_valid_q && completing && out_valid_q && !out_ready;
    assign adv2       = s1_valid_q && !stall2;
    assign in_ready   = reset && !clear && (!s1_valid_q || !stall2);
    assign accept     = in_valid && in_ready;

    always_comb begin
        acc_sum.i  = acc_q.i + ACC_W'(s1_q.i);
        acc_sum.i2 = acc_q.i2 + ACC_W'(s1_q.i2);
        for (int k = 0; k < NUM_TEMPLATES; k++) begin
            acc_sum.ti[k] = acc_q.ti[k] + ACC_W'(s1_q.ti[k]);
        end
    end

    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (adv2) begin
            s1_valid_d = 1'b0;
            if (completing) begin
                res_d       = acc_sum;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (accept) begin
            s1_d       = line_sum;
            s1_valid_d = 1'b1;
        end
        if (clear) begin
            s1_valid_d  = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid              = out_valid_q;
    assign Acc_lines_sum_I        = res_q.i;
    assign Acc_lines_sum_I_square = res_q.i2;
    assign Acc_lines_sum_T_x_I    = res_q.ti;
    assign line_count             = cnt_q;

endmodule

// File: tb/tb_ncc_window_acc.sv
// Scoreboard bench for ncc_window_acc: expected window results are queued at stimulus time
// and popped by a monitor on every output handshake.
module tb_ncc_window_acc;

    localparam int PS = 8;
    localparam int LS = 8;
    localparam int NT = 4;
    localparam int NL = 8;
    localparam int AW = 22;
    localparam int CW = 3;

    typedef struct packed {
        logic [31:0]          i;
        logic [31:0]          i2;
        logic [NT-1:0][31:0]  ti;
    } exp_t;

    logic                          CLK = 1'b0;
    logic                          reset, clear, in_valid, in_ready, out_valid;
    logic                          out_ready;
    logic [LS-1:0][PS-1:0]         i_line;
    logic [LS-1:0][NT-1:0][PS-1:0] t_line;
    logic [AW-1:0]                 sum_i, sum_i2;
    logic [NT-1:0][AW-1:0]         sum_ti;
    logic [CW-1:0]                 line_count;

    exp_t exp_q[$];
    exp_t model;
    int   model_cnt;
    bit   use_model;
    int   ready_mode;
    int   n_vec = 0;
    int   n_err = 0;

    ncc_window_acc u_dut (
        .CLK                   (CLK),
        .reset                 (reset),
        .clear                 (clear),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .I_in_line             (i_line),
        .T_in_line             (t_line),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .Acc_lines_sum_I       (sum_i),
        .Acc_lines_sum_I_square(sum_i2),
        .Acc_lines_sum_T_x_I   (sum_ti),
        .line_count            (line_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: one comparison per result handed to the consumer.
    initial begin
        exp_t e, got;
        forever begin
            @(negedge CLK);
            if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                got.i  = 32'(sum_i);
                got.i2 = 32'(sum_i2);
                for (int k = 0; k < NT; k++) got.ti[k] = 32'(sum_ti[k]);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL result_unexpected: got I=%0d I2=%0d, required no result",
                             got.i, got.i2);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL window_result: got I=%0d I2=%0d TI=%0d/%0d/%0d/%0d, required I=%0d I2=%0d TI=%0d/%0d/%0d/%0d",
                                 got.i, got.i2, got.ti[0], got.ti[1], got.ti[2], got.ti[3],
                                 e.i, e.i2, e.ti[0], e.ti[1], e.ti[2], e.ti[3]);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        n_vec++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic push_exp(input int ei, input int ei2, input int et0, input int et1,
                            input int et2, input int et3);
        exp_t e;
        e.i = ei; e.i2 = ei2;
        e.ti[0] = et0; e.ti[1] = et1; e.ti[2] = et2; e.ti[3] = et3;
        exp_q.push_back(e);
    endtask

    task automatic model_add(input logic [LS-1:0][PS-1:0] il,
                             input logic [LS-1:0][NT-1:0][PS-1:0] tl);
        for (int p = 0; p < LS; p++) begin
            model.i  = model.i + int'(il[p]);
            model.i2 = model.i2 + int'(il[p]) * int'(il[p]);
            for (int k = 0; k < NT; k++) model.ti[k] = model.ti[k] + int'(tl[p][k]) * int'(il[p]);
        end
        model_cnt++;
        if (model_cnt == NL) begin
            exp_q.push_back(model);
            model     = '0;
            model_cnt = 0;
        end
    endtask

    task automatic send_line(input logic [LS-1:0][PS-1:0] il,
                             input logic [LS-1:0][NT-1:0][PS-1:0] tl);
        bit rdy;
        int n = 0;
        i_line   = il;
        t_line   = tl;
        in_valid = 1'b1;
        do begin
            @(negedge CLK);
            rdy = in_ready;
            @(posedge CLK);
            n++;
        end while (!rdy && n < 200);
        #1 in_valid = 1'b0;
        if (!rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required acceptance", n);
        end else if (use_model) begin
            model_add(il, tl);
        end
    endtask

    task automatic send_uniform(input int count, input int ival, input int tval);
        logic [LS-1:0][PS-1:0]         il;
        logic [LS-1:0][NT-1:0][PS-1:0] tl;
        for (int p = 0; p < LS; p++) begin
            il[p] = PS'(ival);
            for (int k = 0; k < NT; k++) tl[p][k] = PS'(tval);
        end
        for (int n = 0; n < count; n++) send_line(il, tl);
    endtask

    task automatic send_ramp_window();
        logic [LS-1:0][PS-1:0]         il;
        logic [LS-1:0][NT-1:0][PS-1:0] tl;
        for (int p = 0; p < LS; p++) begin
            il[p] = PS'(p + 1);
            for (int k = 0; k < NT; k++) tl[p][k] = PS'(k);
        end
        for (int n = 0; n < NL; n++) send_line(il, tl);
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(posedge CLK);
            n++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [LS-1:0][PS-1:0]         il;
        logic [LS-1:0][NT-1:0][PS-1:0] tl;

        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        i_line = '0; t_line = '0;
        use_model = 1'b0; model = '0; model_cnt = 0;
        ready_mode = 1;

        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_sum_i", int'(sum_i), 0);
        check("rst_line_count", int'(line_count), 0);
        @(negedge CLK);
        reset = 1'b1;
        #1 check("rel_in_ready", int'(in_ready), 1);
        @(posedge CLK);
        #1;

        // Saturated pixels, unit templates; also checks two-edge output latency.
        push_exp(16320, 4161600, 16320, 16320, 16320, 16320);
        send_uniform(NL, 255, 1);
        @(negedge CLK);
        check("latency_early", int'(out_valid), 0);
        @(negedge CLK);
        check("latency_valid", int'(out_valid), 1);
        wait_drain(50);

        // Ramp image, per-template constants.
        push_exp(288, 1632, 0, 288, 576, 864);
        send_ramp_window();
        wait_drain(50);

        // Two windows under back-pressure: first held, one extra line absorbed.
        ready_mode = 0;
        idle(2);
        push_exp(64, 64, 0, 0, 0, 0);
        push_exp(128, 256, 384, 384, 384, 384);
        send_uniform(NL, 1, 0);
        send_uniform(NL, 2, 3);
        @(negedge CLK);
        check("bp_in_ready", int'(in_ready), 0);
        check("bp_line_count", int'(line_count), NL - 1);
        for (int n = 0; n < 3; n++) begin
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_sum_i", int'(sum_i), 64);
            check("bp_hold_sum_i2", int'(sum_i2), 64);
            @(negedge CLK);
        end
        ready_mode = 1;
        wait_drain(50);

        // Abort a partial window with clear; clear beats a simultaneous in_valid.
        send_uniform(5, 9, 9);
        @(negedge CLK);
        @(negedge CLK);
        check("pre_clear_count", int'(line_count), 5);
        @(posedge CLK);
        #1;
        clear = 1'b1;
        in_valid = 1'b1;
        @(negedge CLK);
        check("clear_in_ready", int'(in_ready), 0);
        @(posedge CLK);
        #1;
        clear = 1'b0;
        in_valid = 1'b0;
        check("clear_line_count", int'(line_count), 0);
        push_exp(64, 64, 128, 128, 128, 128);
        send_uniform(NL, 1, 2);
        wait_drain(50);

        // Async reset while a result is held and a new window is partial.
        ready_mode = 0;
        idle(2);
        send_uniform(NL + 3, 5, 1);
        @(negedge CLK);
        check("pre_rst_out_valid", int'(out_valid), 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_sum_i", int'(sum_i), 0);
        check("mid_rst_sum_i2", int'(sum_i2), 0);
        check("mid_rst_sum_ti1", int'(sum_ti[1]), 0);
        check("mid_rst_line_count", int'(line_count), 0);
        check("mid_rst_in_ready", int'(in_ready), 0);
        exp_q.delete();
        @(negedge CLK);
        reset = 1'b1;
        ready_mode = 1;
        idle(1);
        push_exp(288, 1632, 0, 288, 576, 864);
        send_ramp_window();
        wait_drain(50);

        // Random lines, random input gaps and output stalls against the model.
        use_model  = 1'b1;
        model      = '0;
        model_cnt  = 0;
        ready_mode = 2;
        for (int n = 0; n < 4 * NL; n++) begin
            idle($urandom_range(0, 2));
            for (int p = 0; p < LS; p++) begin
                il[p] = PS'($urandom);
                for (int k = 0; k < NT; k++) tl[p][k] = PS'($urandom);
            end
            send_line(il, tl);
        end
        wait_drain(300);
        ready_mode = 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
